sha512_buf_reader: RTL and testbench
====================================

Name: sha512_buf_reader

Overview:
- Read-DMA stage directly downstream of the MMIO buffer-descriptor decode.
- Takes one latched buffer descriptor (42-bit cache-line address, 32-bit size in cache lines) and a start pulse.
- Issues CCI-P channel-0 read requests with bounded outstanding depth.
- Reorders out-of-order responses and streams 512-bit lines, in address order, to the SHA-512 core with valid/ready.

Parameters:
- MAX_OUTSTANDING, 16, maximum reads in flight; also reorder-buffer depth; power of 2, range 2..64.
- TAG_W, 4, low mdata bits used as reorder slot; equals log2(MAX_OUTSTANDING).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin transfer of buf_address/buf_size.
- buf_address  in  42  first cache-line address; sampled on start.
- buf_size  in  32  number of cache lines; sampled on start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last line is accepted downstream.
- rd_req_valid  out  1  c0 read request valid.
- rd_req_addr  out  42  request cache-line address.
- rd_req_mdata  out  16  request tag; {zeros, slot}.
- rd_req_almost_full  in  1  c0 TX almost-full; no request may issue while high.
- rd_rsp_valid  in  1  c0 read response valid (single-line, resp type already filtered).
- rd_rsp_mdata  in  16  response tag.
- rd_rsp_data  in  512  response line.
- out_valid  out  1  line available.
- out_data  out  512  line data.
- out_last  out  1  marks final line of buffer.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, any time, including mid-transfer): state IDLE; busy=0, done=0, rd_req_valid=0, out_valid=0, out_last=0, all counters 0, slot-valid bits cleared. In-flight responses arriving after reset release while IDLE are dropped.
- Responses cannot be held off, so rd_rsp_valid is always accepted. Response writes data into slot rd_rsp_mdata[TAG_W-1:0] and sets that slot's valid bit the same cycle.
- State machine: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch address/size, clear req_cnt/rsp_head/out_cnt.
  - buf_size==0 goes straight to DONE.
  - Otherwise go to ISSUE; busy=1 from the cycle after start.
- ISSUE: rd_req_valid is combinational and is 1 when all of the following hold:
  - rd_req_almost_full==0;
  - req_cnt < size;
  - in_flight < MAX_OUTSTANDING, where in_flight = req_cnt - out_cnt, i.e. slots are freed only on downstream acceptance.
  - Each issued request: rd_req_addr = base + req_cnt (42-bit wrap); mdata slot = req_cnt[TAG_W-1:0]; req_cnt increments.
  - When req_cnt reaches size, go to DRAIN.
- DRAIN: no requests. When out_cnt == size, go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Output path:
  - out_valid = valid bit of slot out_cnt[TAG_W-1:0]; out_data = that slot's data.
  - out_last = out_valid && (out_cnt == size-1).
  - On out_valid && out_ready: clear the slot valid bit, out_cnt++.
  - A response write to a slot and a drain of a different slot in the same cycle are both honoured.
  - No combinational path from out_ready to rd_req_valid is required beyond the in_flight compare on registered counts.
- Latency: first request no earlier than 1 cycle after start. out_valid rises the cycle after the matching response write. done pulses the cycle after the final handshake.
- Width rules: counters 32 bits; in_flight computed 32-bit unsigned.
- Error: a response to a slot whose valid bit is already set is a protocol error. Data is overwritten, and the simulation assertion fires.

Optional Feature:
- Macro SHA512_RD_PERF_EN.
- When defined, adds outputs perf_busy_cycles[31:0] and perf_stall_cycles[31:0]:
  - perf_busy_cycles counts cycles with busy=1.
  - perf_stall_cycles counts ISSUE cycles where a request was pending but rd_req_almost_full=1.
  - Both clear on start, saturate at all-ones, and reset to 0.
- When undefined, the ports and counters are absent.

Test Plan:
- Basic: start, addr=0x1000, size=4, responses in order, out_ready=1 -> reqs to 0x1000..0x1003, mdata 0..3; 4 out beats in order, out_last on 4th; done one cycle later.
- Reorder: size=4, responses returned in tag order 3,1,0,2 -> output order still line 0,1,2,3 with matching data.
- Backpressure/credit: MAX_OUTSTANDING=16, size=40, out_ready=0 -> exactly 16 requests then stall. Then raise out_ready -> remaining 24 issue; 40 lines out; done.
- Almost-full: assert rd_req_almost_full for 10 cycles mid-ISSUE -> zero requests in that window; resume after; total requests = size.
- Zero/restart: size=0 -> done in 2nd cycle, no requests. Then start again during busy of a size=8 transfer -> second start ignored.
- Reset mid-transfer: drop rst_n after 5 of 8 requests issued -> all outputs 0 immediately. Late responses ignored; a new start with size=2 completes cleanly.

Source files
------------

// File: rtl/sha512_buf_reader.sv
// sha512_buf_reader
// Read-DMA stage sitting behind the MMIO buffer-descriptor decode. A start
// pulse latches one descriptor (cache-line base address and a size counted in
// lines). The block then issues CCI-P channel-0 reads with a bounded number in
// flight. Responses may return out of order, so a small reorder buffer holds
// them until they can be streamed, in address order, to the SHA-512 core over
// a valid/ready interface.
//
// Optional build macro: SHA512_RD_PERF_EN
//   When defined, two saturating performance counters are added as outputs:
//   perf_busy_cycles and perf_stall_cycles. Without the macro, neither the
//   ports nor the counters exist.
//
// The reorder buffer has one slot per possible outstanding read. The slot is
// chosen by the low TAG_W bits of the request index, and that index also
// travels as the request mdata. A slot is released only when its line is
// accepted downstream, never when its response arrives. This is why the credit
// check uses the request count minus the output count.

module sha512_buf_reader #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int TAG_W           = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         start,
    input  logic [41:0]  buf_address,
    input  logic [31:0]  buf_size,
    output logic         busy,
    output logic         done,

    output logic         rd_req_valid,
    output logic [41:0]  rd_req_addr,
    output logic [15:0]  rd_req_mdata,
    input  logic         rd_req_almost_full,

    input  logic         rd_rsp_valid,
    input  logic [15:0]  rd_rsp_mdata,
    input  logic [511:0] rd_rsp_data,

    output logic         out_valid,
    output logic [511:0] out_data,
    output logic         out_last,
    input  logic         out_ready
`ifdef SHA512_RD_PERF_EN
    ,
    output logic [31:0]  perf_busy_cycles,
    output logic [31:0]  perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Descriptor latched on start. It stays stable for the whole transfer.
    logic [41:0] base_addr;
    logic [31:0] size_q;

    // Lines requested so far, and lines handed downstream so far.
    logic [31:0] req_cnt;
    logic [31:0] out_cnt;
    logic [31:0] in_flight;

    // Reorder buffer: one valid bit and one data line per slot.
    logic [MAX_OUTSTANDING-1:0] slot_valid;
    logic [511:0]               slot_data [MAX_OUTSTANDING];

    logic             active;
    logic             req_room;
    logic             req_fire;
    logic             rsp_accept;
    logic             out_fire;
    logic [TAG_W-1:0] req_slot;
    logic [TAG_W-1:0] rsp_slot;
    logic [TAG_W-1:0] out_slot;

    // The upper tag bits are always zero for requests from this block, so
    // they carry no information on the response side.
    logic unused_rsp_hi;
    assign unused_rsp_hi = ^rd_rsp_mdata[15:TAG_W];

    assign active    = (state == ISSUE) || (state == DRAIN);
    assign busy      = active;
    assign done      = (state == DONE);

    // Lines still occupying a slot: requested but not yet drained.
    assign in_flight = req_cnt - out_cnt;

    // A request is pending when lines remain to be requested and a free slot
    // exists for the line. The credit test uses only registered counts, so
    // out_ready never reaches the request path combinationally.
    assign req_room  = (req_cnt < size_q) && (in_flight < 32'(MAX_OUTSTANDING));
    assign req_fire  = (state == ISSUE) && req_room && !rd_req_almost_full;

    assign req_slot     = req_cnt[TAG_W-1:0];
    assign rd_req_valid = req_fire;
    assign rd_req_addr  = base_addr + {10'd0, req_cnt};
    assign rd_req_mdata = {{(16-TAG_W){1'b0}}, req_slot};

    // The response channel cannot be stalled. Any response that arrives while
    // no transfer is active is a leftover from before a reset, and it is
    // dropped so it cannot pollute the next transfer.
    assign rsp_slot   = rd_rsp_mdata[TAG_W-1:0];
    assign rsp_accept = rd_rsp_valid && active;

    // The head of the output stream is always the slot for the next line in
    // address order. A line is presented as soon as its slot is filled.
    assign out_slot  = out_cnt[TAG_W-1:0];
    assign out_valid = active && slot_valid[out_slot];
    assign out_data  = slot_data[out_slot];
    assign out_last  = out_valid && (out_cnt == (size_q - 32'd1));
    assign out_fire  = out_valid && out_ready;

    // Transfer sequencing: descriptor capture, request and drain counting,
    // and the single-cycle DONE state that produces the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_addr <= 42'd0;
            size_q    <= 32'd0;
            req_cnt   <= 32'd0;
            out_cnt   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr <= buf_address;
                        size_q    <= buf_size;
                        req_cnt   <= 32'd0;
                        out_cnt   <= 32'd0;
                        state     <= (buf_size == 32'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_fire) begin
                        req_cnt <= req_cnt + 32'd1;
                        if ((req_cnt + 32'd1) == size_q) begin
                            state <= DRAIN;
                        end
                    end
                    if (out_fire) begin
                        out_cnt <= out_cnt + 32'd1;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        out_cnt <= out_cnt + 32'd1;
                        if ((out_cnt + 32'd1) == size_q) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slot occupancy. A drained slot is cleared first, and then an arriving
    // response sets its own slot. This lets a fill of one slot and a drain of
    // another land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
        end else begin
            if (out_fire) begin
                slot_valid[out_slot] <= 1'b0;
            end
            if (rsp_accept) begin
                slot_valid[rsp_slot] <= 1'b1;
            end
        end
    end

    // Line storage. No reset is needed because the valid bits qualify every
    // read of this storage.
    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            slot_data[rsp_slot] <= rd_rsp_data;
        end
    end

    // A response that lands on a slot still holding an undrained line is a
    // protocol violation. The line is overwritten, but it is flagged here.
    rsp_slot_free_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        rsp_accept |-> !slot_valid[rsp_slot]
    );

`ifdef SHA512_RD_PERF_EN
    logic req_stall;
    assign req_stall = (state == ISSUE) && req_room && rd_req_almost_full;

    // Saturating counters for busy cycles, and for cycles in which a
    // request was ready but the TX channel reported almost-full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles  <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cycles  <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (active && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (req_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha512_buf_reader.sv
// Directed testbench for sha512_buf_reader.
// Inputs are driven just after each falling edge. Outputs are sampled 1ns
// later, well away from the rising edge. Every line of response data is
// derived from its request address, so the expected output stream can be
// rebuilt from the descriptor alone.

module tb_sha512_buf_reader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [41:0]  buf_address;
    logic [31:0]  buf_size;
    logic         busy;
    logic         done;
    logic         rd_req_valid;
    logic [41:0]  rd_req_addr;
    logic [15:0]  rd_req_mdata;
    logic         rd_req_almost_full;
    logic         rd_rsp_valid;
    logic [15:0]  rd_rsp_mdata;
    logic [511:0] rd_rsp_data;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_last;
    logic         out_ready;

    sha512_buf_reader #(.MAX_OUTSTANDING(16), .TAG_W(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .buf_address        (buf_address),
        .buf_size           (buf_size),
        .busy               (busy),
        .done               (done),
        .rd_req_valid       (rd_req_valid),
        .rd_req_addr        (rd_req_addr),
        .rd_req_mdata       (rd_req_mdata),
        .rd_req_almost_full (rd_req_almost_full),
        .rd_rsp_valid       (rd_rsp_valid),
        .rd_rsp_mdata       (rd_rsp_mdata),
        .rd_rsp_data        (rd_rsp_data),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_last           (out_last),
        .out_ready          (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [41:0]  iss_addr[$];
    logic [15:0]  iss_mdata[$];
    logic [41:0]  pend_addr[$];
    logic [15:0]  pend_tag[$];
    logic [511:0] out_q[$];
    logic         out_last_q[$];
    int done_cnt;
    int done_cyc;
    int last_hs_cyc;
    int first_hs_cyc;
    int first_rsp_cyc;

    // Each line carries its own address, so misordered data is detected.
    function automatic logic [511:0] mk_line(input logic [41:0] a);
        logic [511:0] l;
        l = {8{22'h0, a}};
        return l ^ {16{32'hA5A5_0F0F}};
    endfunction

    task automatic clear_records();
        iss_addr.delete();
        iss_mdata.delete();
        pend_addr.delete();
        pend_tag.delete();
        out_q.delete();
        out_last_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        last_hs_cyc   = -1;
        first_hs_cyc  = -1;
        first_rsp_cyc = -1;
    endtask

    // Run one clock. Observe this cycle's outputs, then advance to the next
    // falling edge and drop the one-cycle inputs.
    task automatic tick();
        #1;
        if (rd_req_valid === 1'b1) begin
            iss_addr.push_back(rd_req_addr);
            iss_mdata.push_back(rd_req_mdata);
            pend_addr.push_back(rd_req_addr);
            pend_tag.push_back(rd_req_mdata);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_q.push_back(out_data);
            out_last_q.push_back(out_last);
            last_hs_cyc = cyc;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (rd_rsp_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
        start        = 1'b0;
        rd_rsp_valid = 1'b0;
    endtask

    task automatic respond_at(input int idx);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = pend_tag[idx];
        rd_rsp_data  = mk_line(pend_addr[idx]);
        pend_tag.delete(idx);
        pend_addr.delete(idx);
    endtask

    task automatic respond_tag(input int tag);
        int idx;
        idx = -1;
        for (int i = 0; i < pend_tag.size(); i++) begin
            if (int'(pend_tag[i]) == tag && idx < 0) idx = i;
        end
        if (idx >= 0) respond_at(idx);
    endtask

    task automatic run_ticks(input int n, input bit do_rsp);
        for (int i = 0; i < n; i++) begin
            if (do_rsp && pend_tag.size() > 0) respond_at(0);
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int d0;
        d0 = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (pend_tag.size() > 0) respond_at(0);
            tick();
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic kick(input logic [41:0] a, input logic [31:0] s);
        buf_address = a;
        buf_size    = s;
        start       = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b expected 0", rd_req_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last: got %b expected 0", out_last); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        int n0;
        clear_records();
        out_ready = 1'b1;
        kick(42'h1000, 32'd4);
        n0 = iss_addr.size();
        checks++; if (n0 !== 0) begin errors++; $display("[TB] FAIL basic_no_req_on_start: got %0d expected 0", n0); end
        wait_done(50, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
        checks++; if (iss_addr.size() !== 4) begin errors++; $display("[TB] FAIL basic_req_count: got %0d expected 4", iss_addr.size()); end
        for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
            checks++; if (iss_addr[i] !== 42'h1000 + 42'(i)) begin errors++; $display("[TB] FAIL basic_req_addr%0d: got %0h expected %0h", i, iss_addr[i], 42'h1000 + 42'(i)); end
            checks++; if (iss_mdata[i] !== 16'(i)) begin errors++; $display("[TB] FAIL basic_req_mdata%0d: got %0h expected %0h", i, iss_mdata[i], i); end
        end
        checks++; if (out_q.size() !== 4) begin errors++; $display("[TB] FAIL basic_out_count: got %0d expected 4", out_q.size()); end
        for (int k = 0; k < 4 && k < out_q.size(); k++) begin
            checks++; if (out_q[k] !== mk_line(42'h1000 + 42'(k))) begin errors++; $display("[TB] FAIL basic_out_data%0d: got %0h expected %0h", k, out_q[k][63:0], mk_line(42'h1000 + 42'(k)) & 512'hFFFF_FFFF_FFFF_FFFF); end
            checks++; if (out_last_q[k] !== (k == 3)) begin errors++; $display("[TB] FAIL basic_out_last%0d: got %b expected %b", k, out_last_q[k], (k == 3)); end
        end
        checks++; if (done_cyc !== last_hs_cyc + 1) begin errors++; $display("[TB] FAIL basic_done_latency: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
        checks++; if (first_hs_cyc !== first_rsp_cyc + 1) begin errors++; $display("[TB] FAIL basic_out_latency: got %0d expected %0d", first_hs_cyc, first_rsp_cyc + 1); end
        run_ticks(3, 1'b0);
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reorder();
        bit to;
        clear_records();
        out_ready = 1'b0;
        kick(42'h2000, 32'd4);
        run_ticks(6, 1'b0);
        checks++; if (iss_addr.size() !== 4) begin errors++; $display("[TB] FAIL reorder_req_count: got %0d expected 4", iss_addr.size()); end
        respond_tag(3); tick();
        respond_tag(1); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reorder_hold: got %b expected 0", out_valid); end
        respond_tag(0); tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL reorder_head_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== mk_line(42'h2000)) begin errors++; $display("[TB] FAIL reorder_head_data: got %0h expected %0h", out_data[63:0], mk_line(42'h2000) & 512'hFFFF_FFFF_FFFF_FFFF); end
        respond_tag(2); tick();
        out_ready = 1'b1;
        wait_done(20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL reorder_timeout: got %b expected 0", to); end
        checks++; if (out_q.size() !== 4) begin errors++; $display("[TB] FAIL reorder_out_count: got %0d expected 4", out_q.size()); end
        for (int k = 0; k < 4 && k < out_q.size(); k++) begin
            checks++; if (out_q[k] !== mk_line(42'h2000 + 42'(k))) begin errors++; $display("[TB] FAIL reorder_out_data%0d: got %0h expected %0h", k, out_q[k][63:0], mk_line(42'h2000 + 42'(k)) & 512'hFFFF_FFFF_FFFF_FFFF); end
        end
        checks++; if (out_last_q.size() == 4 && out_last_q[3] !== 1'b1) begin errors++; $display("[TB] FAIL reorder_last: got %b expected 1", out_last_q[3]); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        clear_records();
        out_ready = 1'b0;
        kick(42'h10000, 32'd40);
        run_ticks(60, 1'b1);
        checks++; if (iss_addr.size() !== 16) begin errors++; $display("[TB] FAIL bp_credit_stall: got %0d expected 16", iss_addr.size()); end
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_blocked: got %b expected 0", rd_req_valid); end
        out_ready = 1'b1;
        wait_done(500, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout: got %b expected 0", to); end
        checks++; if (iss_addr.size() !== 40) begin errors++; $display("[TB] FAIL bp_req_total: got %0d expected 40", iss_addr.size()); end
        checks++; if (out_q.size() !== 40) begin errors++; $display("[TB] FAIL bp_out_count: got %0d expected 40", out_q.size()); end
        bad = 0;
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== mk_line(42'h10000 + 42'(k))) bad++;
            if (out_last_q[k] !== (k == 39)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_out_stream: got %0d bad beats expected 0", bad); end
    endtask

    task automatic test_almost_full();
        bit to;
        int n0;
        int bad;
        clear_records();
        out_ready = 1'b1;
        kick(42'h3000, 32'd12);
        run_ticks(2, 1'b1);
        checks++; if (iss_addr.size() !== 2) begin errors++; $display("[TB] FAIL af_pre_count: got %0d expected 2", iss_addr.size()); end
        rd_req_almost_full = 1'b1;
        n0 = iss_addr.size();
        run_ticks(10, 1'b1);
        checks++; if (iss_addr.size() !== n0) begin errors++; $display("[TB] FAIL af_window_reqs: got %0d expected %0d", iss_addr.size(), n0); end
        rd_req_almost_full = 1'b0;
        wait_done(100, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL af_timeout: got %b expected 0", to); end
        checks++; if (iss_addr.size() !== 12) begin errors++; $display("[TB] FAIL af_req_total: got %0d expected 12", iss_addr.size()); end
        bad = 0;
        for (int i = 0; i < iss_addr.size(); i++) begin
            if (iss_addr[i] !== 42'h3000 + 42'(i)) bad++;
            if (iss_mdata[i] !== 16'(i % 16)) bad++;
        end
        for (int k = 0; k < out_q.size(); k++) begin
            if (out_q[k] !== mk_line(42'h3000 + 42'(k))) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL af_stream: got %0d bad items expected 0", bad); end
        checks++; if (out_q.size() !== 12) begin errors++; $display("[TB] FAIL af_out_count: got %0d expected 12", out_q.size()); end
    endtask

    task automatic test_zero_restart();
        bit to;
        clear_records();
        out_ready = 1'b1;
        kick(42'h7000, 32'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
        buf_address = 42'h7100;
        buf_size    = 32'd3;
        start       = 1'b1;
        tick();
        run_ticks(3, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_start_in_done: got %b expected 0", busy); end
        checks++; if (iss_addr.size() !== 0) begin errors++; $display("[TB] FAIL zero_no_reqs: got %0d expected 0", iss_addr.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL zero_done_pulses: got %0d expected 1", done_cnt); end

        clear_records();
        out_ready = 1'b0;
        kick(42'h4000, 32'd8);
        run_ticks(3, 1'b0);
        kick(42'h9000, 32'd2);
        out_ready = 1'b1;
        wait_done(100, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_timeout: got %b expected 0", to); end
        checks++; if (iss_addr.size() !== 8) begin errors++; $display("[TB] FAIL busy_start_reqs: got %0d expected 8", iss_addr.size()); end
        checks++; if (iss_addr.size() == 8 && iss_addr[7] !== 42'h4007) begin errors++; $display("[TB] FAIL busy_start_addr: got %0h expected 4007", iss_addr[7]); end
        checks++; if (out_q.size() !== 8) begin errors++; $display("[TB] FAIL busy_start_outs: got %0d expected 8", out_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_records();
        out_ready = 1'b0;
        kick(42'h5000, 32'd8);
        run_ticks(5, 1'b0);
        checks++; if (iss_addr.size() !== 5) begin errors++; $display("[TB] FAIL rmid_pre_reqs: got %0d expected 5", iss_addr.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req_valid: got %b expected 0", rd_req_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(6, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle_after: got %b expected 0", busy); end
        clear_records();
        out_ready = 1'b1;
        kick(42'h6000, 32'd2);
        wait_done(40, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL rmid_timeout: got %b expected 0", to); end
        checks++; if (out_q.size() !== 2) begin errors++; $display("[TB] FAIL rmid_out_count: got %0d expected 2", out_q.size()); end
        for (int k = 0; k < 2 && k < out_q.size(); k++) begin
            checks++; if (out_q[k] !== mk_line(42'h6000 + 42'(k))) begin errors++; $display("[TB] FAIL rmid_out_data%0d: got %0h expected %0h", k, out_q[k][63:0], mk_line(42'h6000 + 42'(k)) & 512'hFFFF_FFFF_FFFF_FFFF); end
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        start              = 1'b0;
        buf_address        = '0;
        buf_size           = '0;
        rd_req_almost_full = 1'b0;
        rd_rsp_valid       = 1'b0;
        rd_rsp_mdata       = '0;
        rd_rsp_data        = '0;
        out_ready          = 1'b0;
        clear_records();
        test_reset();
        test_basic();
        test_reorder();
        test_backpressure();
        test_almost_full();
        test_zero_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
